// File: rtl/tt_um_pchri03_top.sv
// rtl/tt_um_pchri03_top.sv - APB3 zero-wait-state slave with scratch registers, checksum and write counter
module tt_um_pchri03_top (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam logic [7:0] ID_VALUE = 8'hA5;

    logic [2:0] paddr;
    logic       penable;
    logic       pwrite;
    logic       access;
    logic       wr_ok;
    logic       pready;
    logic       pslverr;
    logic [7:0] sum_val;
    logic [7:0] xor_val;
    logic [7:0] rd_mux;
    logic [7:0] reg_q [4];
    logic [7:0] reg_d [4];
    logic [7:0] wcnt_q;
    logic [7:0] wcnt_d;
    logic       unused_bits;

    assign paddr       = uio_in[2:0];
    assign penable     = uio_in[3];
    assign pwrite      = uio_in[4];
    assign unused_bits = &{1'b0, uio_in[7:5]};

    assign access = ena & penable;
    // Only the four scratch registers are writable; addresses 4-7 have bit 2 set.
    assign wr_ok  = access & pwrite & ~paddr[2];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            reg_d[i] = reg_q[i];
        end
        wcnt_d = wcnt_q;
        if (wr_ok) begin
            reg_d[paddr[1:0]] = ui_in;
            wcnt_d            = wcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                reg_q[i] <= 8'h00;
            end
            wcnt_q <= 8'h00;
        end else begin
            for (int i = 0; i < 4; i++) begin
                reg_q[i] <= reg_d[i];
            end
            wcnt_q <= wcnt_d;
        end
    end

    assign sum_val = reg_q[0] + reg_q[1] + reg_q[2] + reg_q[3];
    assign xor_val = reg_q[0] ^ reg_q[1] ^ reg_q[2] ^ reg_q[3];

    always_comb begin
        rd_mux = 8'h00;
        case (paddr)
            3'd0:    rd_mux = reg_q[0];
            3'd1:    rd_mux = reg_q[1];
            3'd2:    rd_mux = reg_q[2];
            3'd3:    rd_mux = reg_q[3];
            3'd4:    rd_mux = sum_val;
            3'd5:    rd_mux = xor_val;
            3'd6:    rd_mux = ID_VALUE;
            default: rd_mux = wcnt_q;
        endcase
    end

    // Gating with rst_n keeps the constant ID off the bus while held in reset.
    assign uo_out  = (rst_n & ena & ~pwrite) ? rd_mux : 8'h00;
    assign pready  = rst_n & access;
    assign pslverr = pready & pwrite & paddr[2];
    assign uio_out = {1'b0, pslverr, pready, 5'b0_0000};
    assign uio_oe  = 8'b0110_0000;

endmodule

// File: tb/tb_tt_um_pchri03_top.sv
// tb/tb_tt_um_pchri03_top.sv - self-checking bench for tt_um_pchri03_top
module tb_tt_um_pchri03_top;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int errors;

    int m_reg [4];
    int m_wcnt;

    logic [7:0] s_rdata;
    logic       s_ready;
    logic       s_err;

    tt_um_pchri03_top dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h expected=%02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_rdata();
        int a;
        a = int'(uio_in[2:0]);
        if (!rst_n || !ena || uio_in[4]) return 8'h00;
        case (a)
            0, 1, 2, 3: return 8'(m_reg[a]);
            4:          return 8'((m_reg[0] + m_reg[1] + m_reg[2] + m_reg[3]) % 256);
            5:          return 8'(m_reg[0] ^ m_reg[1] ^ m_reg[2] ^ m_reg[3]);
            6:          return 8'hA5;
            default:    return 8'(m_wcnt);
        endcase
    endfunction

    function automatic logic [7:0] model_uio_out();
        logic rdy;
        logic err;
        rdy = rst_n && ena && uio_in[3];
        err = rdy && uio_in[4] && (uio_in[2:0] >= 3'd4);
        return {1'b0, err, rdy, 5'b0};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_reg[i] = 0;
        m_wcnt = 0;
    endtask

    // One clock: compare every output at the falling edge, then advance the model at the rising edge.
    task automatic tick();
        @(negedge clk);
        check("cyc_prdata", uo_out, model_rdata());
        check("cyc_uio_out", uio_out, model_uio_out());
        check("cyc_uio_oe", uio_oe, 8'h60);
        s_rdata = uo_out;
        s_ready = uio_out[5];
        s_err   = uio_out[6];
        @(posedge clk);
        if (rst_n && ena && uio_in[3] && uio_in[4] && uio_in[2:0] < 3'd4) begin
            m_reg[uio_in[1:0]] = int'(ui_in);
            m_wcnt = (m_wcnt + 1) % 256;
        end
        #1;
    endtask

    task automatic set_bus(input logic e, input logic pen, input logic pw,
                           input logic [2:0] addr, input logic [7:0] data);
        ena    = e;
        ui_in  = data;
        uio_in = {3'b000, pw, pen, addr};
    endtask

    task automatic apb(input logic pw, input logic [2:0] addr, input logic [7:0] data);
        set_bus(1'b1, 1'b0, pw, addr, data);
        tick();
        set_bus(1'b1, 1'b1, pw, addr, data);
        tick();
    endtask

    task automatic rd(input string name, input logic [2:0] addr, input logic [7:0] exp);
        apb(1'b0, addr, 8'h00);
        check(name, s_rdata, exp);
        check({name, "_ready"}, {7'd0, s_ready}, 8'h01);
        check({name, "_slverr"}, {7'd0, s_err}, 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        set_bus(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    logic [7:0] id_exp [8];
    logic [7:0] wr_pat [4];

    initial begin
        checks = 0;
        errors = 0;
        model_clear();
        rst_n = 1'b0;
        set_bus(1'b1, 1'b0, 1'b0, 3'd6, 8'h00);
        #5;
        check("rst_prdata", uo_out, 8'h00);
        check("rst_uio_out", uio_out, 8'h00);
        check("rst_uio_oe", uio_oe, 8'h60);
        tick();
        rst_n = 1'b1;
        set_bus(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        tick();

        id_exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00};
        for (int a = 0; a < 8; a++) rd($sformatf("reset_rd%0d", a), 3'(a), id_exp[a]);

        wr_pat = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int a = 0; a < 4; a++) begin
            apb(1'b1, 3'(a), wr_pat[a]);
            check($sformatf("wr%0d_ready", a), {7'd0, s_ready}, 8'h01);
            check($sformatf("wr%0d_slverr", a), {7'd0, s_err}, 8'h00);
        end
        for (int a = 0; a < 4; a++) rd($sformatf("pat_rd%0d", a), 3'(a), wr_pat[a]);
        rd("sum", 3'd4, 8'h38);
        rd("xor", 3'd5, 8'h22);
        rd("wcnt4", 3'd7, 8'h04);

        apb(1'b1, 3'd6, 8'h55);
        check("err_wr_slverr", {7'd0, s_err}, 8'h01);
        check("err_wr_ready", {7'd0, s_ready}, 8'h01);
        rd("id_after_err", 3'd6, 8'hA5);
        rd("wcnt_after_err", 3'd7, 8'h04);
        set_bus(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        tick();

        do_reset();
        for (int i = 0; i < 256; i++) apb(1'b1, 3'(i % 4), 8'(i));
        rd("wcnt_wrap", 3'd7, 8'h00);
        rd("wrap_reg0", 3'd0, 8'hFC);
        rd("wrap_sum", 3'd4, 8'hF6);
        rd("wrap_xor", 3'd5, 8'h00);

        set_bus(1'b0, 1'b1, 1'b1, 3'd0, 8'h11);
        tick();
        check("noena_ready", {7'd0, s_ready}, 8'h00);
        check("noena_prdata", s_rdata, 8'h00);
        rd("noena_reg0", 3'd0, 8'hFC);
        rd("noena_wcnt", 3'd7, 8'h00);

        apb(1'b1, 3'd2, 8'h33);
        set_bus(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        tick();
        do_reset();
        set_bus(1'b1, 1'b0, 1'b1, 3'd2, 8'h99);
        tick();
        set_bus(1'b1, 1'b1, 1'b1, 3'd2, 8'h99);
        #3;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("midrst_prdata", uo_out, 8'h00);
        check("midrst_uio_out", uio_out, 8'h00);
        check("midrst_uio_oe", uio_oe, 8'h60);
        tick();
        tick();
        rst_n = 1'b1;
        set_bus(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        tick();
        rd("midrst_reg2", 3'd2, 8'h00);
        rd("midrst_wcnt", 3'd7, 8'h00);
        set_bus(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_um_pchri03_top.md
TT_UM_PCHRI03_TOP -- requirements
Module: tt_um_pchri03_top

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single system clock (APB PCLK); all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low (APB PRESETn).
REQ-004 ena  input  1  APB PSEL; high selects the slave.
REQ-005 ui_in  input  8  APB PWDATA.
REQ-006 uio_in  input  8  [2:0]=PADDR, [3]=PENABLE, [4]=PWRITE; [7:5] ignored.
REQ-007 uo_out  output  8  APB PRDATA.
REQ-008 uio_out  output  8  [5]=PREADY, [6]=PSLVERR; bits [4:0] and [7] driven 0.
REQ-009 uio_oe  output  8  constant 8'b0110_0000 (bits 5,6 outputs; all others inputs).

Function
REQ-010 SHALL implement an APB3 zero-wait-state slave: setup phase = ena&~PENABLE, access phase = ena&PENABLE.
REQ-011 PREADY SHALL be combinational: 1 exactly in access phase, else 0; no wait states ever.
REQ-012 Register map: 0-3 = REG0..REG3, 8-bit read/write scratch registers.
REQ-013 Address 4 = SUM, read-only: (REG0+REG1+REG2+REG3) mod 256.
REQ-014 Address 5 = XOR, read-only: REG0^REG1^REG2^REG3.
REQ-015 Address 6 = ID, read-only constant 0xA5.
REQ-016 Address 7 = WCNT, read-only 8-bit count of successful writes, wraps 0xFF->0x00.
REQ-017 Write SHALL commit on the rising clk edge in access phase with PWRITE=1 and address 0-3; PWDATA goes to the addressed register and WCNT increments by 1 at the same edge.
REQ-018 SUM/XOR SHALL be combinational from REG0-3 and reflect a write from the next cycle onward.
REQ-019 Write to address 4-7: PSLVERR=1 (combinational, during that access phase only); no register and no WCNT change.
REQ-020 PSLVERR SHALL be 0 at all other times; reads never error.
REQ-021 PRDATA SHALL be combinational: addressed register value during setup and access phase of a read (ena=1, PWRITE=0); 0x00 otherwise, including during writes.
REQ-022 Setup phase alone SHALL cause no state change; an access phase without a preceding setup phase is still honoured.
REQ-023 Back-to-back transfers (setup immediately after access, ena held high) SHALL be supported with no idle cycle.
REQ-024 ena=0 SHALL suppress PREADY, PSLVERR, PRDATA and all writes regardless of PENABLE/PWRITE.

Reset
REQ-025 rst_n=0 SHALL immediately (asynchronously) clear REG0-3 and WCNT to 0x00; thus SUM=0x00, XOR=0x00.
REQ-026 Outputs during reset: uo_out=0x00, PREADY=0, PSLVERR=0, uio_oe=0x60.
REQ-027 Reset asserted mid-transfer SHALL abort it with no commit; first transfer after rst_n rises is handled normally.
REQ-028 rst_n deassertion is synchronised externally; no internal reset synchroniser required.

Verification
REQ-029 Reset, then read addresses 0-7 -> 00,00,00,00,00,00,A5,00; PREADY=1, PSLVERR=0 each access.
REQ-030 Write DE,AD,BE,EF to addresses 0-3 (setup+access, 20 ns clk period) then read 0-3 -> DE,AD,BE,EF; PREADY=1 each access.
REQ-031 After REQ-030 writes: read 4 -> 0x38, read 5 -> 0x22, read 7 -> 0x04.
REQ-032 Write 0x55 to address 6 -> PSLVERR=1 and PREADY=1 in access; read 6 -> 0xA5, read 7 count unchanged.
REQ-033 256 successful writes after reset -> WCNT reads 0x00 (wrap); ena=0 with PENABLE=1, PWRITE=1 -> no register change, PREADY=0.
REQ-034 Assert rst_n=0 during a write access phase -> target register stays 0x00, outputs per REQ-026 without waiting for a clk edge.
